mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single `memory` instance between two requesters: requester 0 is CPU instruction fetch, requester 1 is CPU load/store or a testbench loader.
- Sits in `risc_v_circuit` between the requesters and the memory request/ack handshake.
- Grants round-robin, allows one outstanding transaction, and routes read data and ack back to the owner.
- Has an optional watchdog that aborts a transaction whose ack never arrives.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, max cycles waiting for mem_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_req_valid, r1_req_valid  in  1  request pending; held stable until that requester's ack.
- r0_addr, r1_addr  in  ADDR_W  request address.
- r0_wr_data, r1_wr_data  in  DATA_W  write data.
- r0_rd_wr, r1_rd_wr  in  1  0 = read, 1 = write.
- r0_ack, r1_ack  out  1  one-cycle completion pulse.
- r0_err, r1_err  out  1  valid with ack; 1 = timed out.
- r0_rd_data, r1_rd_data  out  DATA_W  read data, valid with ack.
- mem_rd_addr  out  ADDR_W  read address; 0 unless the active request is a read.
- mem_wr_addr  out  ADDR_W  write address; 0 unless the active request is a write.
- mem_wr_data  out  DATA_W  write data; 0 unless the active request is a write.
- mem_rd_wr  out  1  0 = read.
- mem_req_valid  out  1  request to memory.
- mem_rd_data  in  DATA_W  memory read data.
- mem_ack  in  1  memory completion.
- owner  out  1  index of the current or last granted requester (debug).

Behaviour:
- All outputs are registered. On reset every output is 0.
  - State = IDLE, last_grant = 1 (requester 0 wins first), watchdog counter = 0.
- FSM IDLE:
  - No request: stay in IDLE.
  - Otherwise grant one requester:
    - Only one valid: grant it.
    - Both valid: grant the requester that is not last_grant.
  - Latch the granted addr, wr_data and rd_wr.
  - Set owner and last_grant to the granted index.
  - Go to REQ.
- FSM REQ:
  - mem_req_valid = 1; mem_* driven from the latched fields, with the unused address/data fields = 0.
  - Fields stay constant for the whole of REQ.
  - On mem_ack: capture mem_rd_data (capture 0 for writes), err = 0, go to RESP.
  - Watchdog: counter increments each REQ cycle without ack.
    - If TIMEOUT != 0 and counter reaches TIMEOUT-1 with no ack: data = 0, err = 1, go to RESP.
    - mem_ack arriving in that same cycle wins: no error.
- FSM RESP, exactly 1 cycle:
  - mem_req_valid = 0.
  - Owner's rN_ack = 1 with rN_rd_data and rN_err; the other requester's ack = 0.
  - Counter cleared. Go to IDLE.
- Latency: request seen in IDLE at cycle 0 → mem_req_valid in cycle 1 → mem_ack in cycle k → rN_ack in cycle k+1.
  - Minimum 3 cycles per transaction (k = 1).
- Requester protocol: drop or replace the request in the cycle after its ack.
  - A request still asserted in IDLE after RESP is a new request.
- rN_rd_data holds its last value outside ack; only valid with ack.
- mem_ack in IDLE or RESP is ignored, with no state change.
- mem_rd_data is sampled only on a REQ-state ack.
- Requester inputs are ignored outside IDLE; changing them mid-transaction has no effect.
- Reset mid-transaction: immediate return to IDLE with all outputs 0.
  - The in-flight memory access is abandoned; a later stray mem_ack is ignored.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

Decomposition:
- Package `mem_arb_pkg`:
  - `arb_state_e` enum {IDLE, REQ, RESP}.
  - `mem_req_t` struct {addr, wr_data, rd_wr}.
  - Localparam for the requester count (2).
- Sub-module `rr_arbiter2`: combinational; inputs two valid bits and last_grant; outputs grant_valid and grant_idx.
- The FSM, request latch, watchdog and response routing stay in `mem_arbiter`.

Test Plan:
- r0 read addr 0x10, memory acks in cycle 1 with 0xDEADBEEF → mem_req_valid with mem_rd_addr = 0x10, mem_rd_wr = 0; r0_ack with r0_rd_data = 0xDEADBEEF, err = 0 at cycle 2; r1_ack stays 0.
- r1 write addr 0x20, data 0x1234, memory ack delayed 5 cycles → mem_wr_addr = 0x20, mem_wr_data = 0x1234, mem_rd_addr = 0, fields stable for all 5 cycles; r1_ack exactly 1 cycle, r1_rd_data = 0.
- Both valid from reset, 4 transactions → grant order r0, r1, r0, r1; owner tracks each grant.
- TIMEOUT = 8, memory never acks → mem_req_valid held 8 cycles; then owner ack with err = 1, data = 0; next request proceeds normally.
- reset asserted mid-REQ, then mem_ack arrives after reset release → all outputs 0 immediately; stray ack ignored, no rN_ack.
- mem_ack pulsed while IDLE with no requests → no state change, no ack outputs.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Request fields are carried at the full 32-bit memory width of the core.
package mem_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wr_data;
    logic                  rd_wr;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick: with both requesters valid, the one that did not
// win last time is granted; otherwise the single valid requester wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |valid;
  assign grant_idx   = (valid == 2'b11) ? ~last_grant : valid[1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two requesters: round-robin grant, a single
// outstanding transaction, response routing and an optional ack watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wr_data,
  input  logic              r0_rd_wr,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rd_data,
  input  logic              r1_req_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wr_data,
  input  logic              r1_rd_wr,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rd_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_wr,
  output logic              mem_req_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_ack,
  output logic              owner
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e        state_q, state_d;
  mem_req_t          req_q, req_d;
  mem_req_t          reqs [NUM_REQ];
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_valid, grant_idx;
  logic              timeout_hit;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  logic [NUM_REQ-1:0] ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0]  rd_data_q [NUM_REQ];
  logic [DATA_W-1:0]  rd_data_d [NUM_REQ];
  logic               mem_req_valid_q, mem_req_valid_d;
  logic               mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_W-1:0]  mem_rd_addr_q, mem_rd_addr_d;
  logic [ADDR_W-1:0]  mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_W-1:0]  mem_wr_data_q, mem_wr_data_d;

  assign reqs[0] = '{addr: MEM_ADDR_W'(r0_addr), wr_data: MEM_DATA_W'(r0_wr_data), rd_wr: r0_rd_wr};
  assign reqs[1] = '{addr: MEM_ADDR_W'(r1_addr), wr_data: MEM_DATA_W'(r1_wr_data), rd_wr: r1_rd_wr};

  rr_arbiter2 u_rr (
    .valid       ({r1_req_valid, r0_req_valid}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Counter holds the number of REQ cycles already spent without an ack.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      req_q           <= '0;
      last_grant_q    <= 1'b1;
      owner_q         <= 1'b0;
      cnt_q           <= '0;
      ack_q           <= '0;
      err_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_rd_wr_q     <= 1'b0;
      mem_rd_addr_q   <= '0;
      mem_wr_addr_q   <= '0;
      mem_wr_data_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) rd_data_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      ack_q           <= ack_d;
      err_q           <= err_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_rd_wr_q     <= mem_rd_wr_d;
      mem_rd_addr_q   <= mem_rd_addr_d;
      mem_wr_addr_q   <= mem_wr_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      for (int i = 0; i < NUM_REQ; i++) rd_data_q[i] <= rd_data_d[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    resp_err     = 1'b0;
    resp_data    = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = REQ;
          req_d        = reqs[grant_idx];
          last_grant_d = grant_idx;
          owner_d      = grant_idx;
          cnt_d        = '0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d   = RESP;
          resp_data = req_q.rd_wr ? '0 : mem_rd_data;
        end else if (timeout_hit) begin
          state_d  = RESP;
          resp_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    mem_req_valid_d = (state_d == REQ);
    mem_rd_wr_d     = (state_d == REQ) && req_d.rd_wr;
    mem_rd_addr_d   = (state_d == REQ && !req_d.rd_wr) ? ADDR_W'(req_d.addr) : '0;
    mem_wr_addr_d   = (state_d == REQ &&  req_d.rd_wr) ? ADDR_W'(req_d.addr) : '0;
    mem_wr_data_d   = (state_d == REQ &&  req_d.rd_wr) ? DATA_W'(req_d.wr_data) : '0;
    ack_d           = '0;
    err_d           = '0;
    rd_data_d       = rd_data_q;
    if (state_q == REQ && state_d == RESP) begin
      ack_d[owner_q]     = 1'b1;
      err_d[owner_q]     = resp_err;
      rd_data_d[owner_q] = resp_data;
    end
  end

  assign r0_ack        = ack_q[0];
  assign r1_ack        = ack_q[1];
  assign r0_err        = err_q[0];
  assign r1_err        = err_q[1];
  assign r0_rd_data    = rd_data_q[0];
  assign r1_rd_data    = rd_data_q[1];
  assign mem_req_valid = mem_req_valid_q;
  assign mem_rd_wr     = mem_rd_wr_q;
  assign mem_rd_addr   = mem_rd_addr_q;
  assign mem_wr_addr   = mem_wr_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of the
// grant order, memory latency, watchdog outcome and response data.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req_valid, r1_req_valid;
  logic [31:0] r0_addr, r1_addr, r0_wr_data, r1_wr_data;
  logic        r0_rd_wr, r1_rd_wr;
  logic        r0_ack, r1_ack, r0_err, r1_err;
  logic [31:0] r0_rd_data, r1_rd_data;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data, mem_rd_data;
  logic        mem_rd_wr, mem_req_valid, mem_ack, owner;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Model state: who won last, and the data each requester last received.
  bit          m_last;
  logic [31:0] m_data [2];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_addr(r0_addr), .r0_wr_data(r0_wr_data), .r0_rd_wr(r0_rd_wr),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rd_data(r0_rd_data),
    .r1_req_valid(r1_req_valid), .r1_addr(r1_addr), .r1_wr_data(r1_wr_data), .r1_rd_wr(r1_rd_wr),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rd_data(r1_rd_data),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_wr(mem_rd_wr), .mem_req_valid(mem_req_valid), .mem_rd_data(mem_rd_data),
    .mem_ack(mem_ack), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {r0_ack, r1_ack, r0_err, r1_err, r0_rd_data, r1_rd_data, mem_rd_addr,
            mem_wr_addr[7:0], mem_wr_data[7:0], mem_rd_wr, mem_req_valid, owner};
  endfunction

  task automatic drop_reqs();
    r0_req_valid = 0; r1_req_valid = 0;
    r0_addr = 0; r1_addr = 0; r0_wr_data = 0; r1_wr_data = 0;
    r0_rd_wr = 0; r1_rd_wr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; mem_ack = 0; mem_rd_data = 0;
    drop_reqs();
    #1;
    check("reset_outs_zero", all_outs(), '0);
    check("reset_wide_zero", {mem_wr_addr, mem_wr_data}, '0);
    repeat (2) @(negedge clk);
    reset = 0;
    m_last = 1'b1;
    m_data[0] = '0; m_data[1] = '0;
  endtask

  // One whole transaction, starting at a negedge while the DUT is idle.
  // lat: REQ cycle in which memory acks (1-based); 0 = memory never acks.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input bit w0, input bit w1,
                        input int lat, input logic [31:0] mdata, input bit scramble);
    bit          w, wr, err;
    logic [31:0] addr, wdata, edata;
    logic [97:0] fields;
    int          j;

    r0_req_valid = v0; r0_addr = a0; r0_wr_data = d0; r0_rd_wr = w0;
    r1_req_valid = v1; r1_addr = a1; r1_wr_data = d1; r1_rd_wr = w1;

    w      = (v0 && v1) ? !m_last : v1;
    m_last = w;
    addr   = w ? a1 : a0;
    wdata  = w ? d1 : d0;
    wr     = w ? w1 : w0;
    err    = (lat == 0) || (lat > TO);
    edata  = (err || wr) ? 32'h0 : mdata;
    fields = {1'b1, wr, wr ? 32'h0 : addr, wr ? addr : 32'h0, wr ? wdata : 32'h0};

    j = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      mem_ack = 0;
      j++;
      check("req_fields", {mem_req_valid, mem_rd_wr, mem_rd_addr, mem_wr_addr, mem_wr_data}, fields);
      check("owner", owner, w);
      check("no_ack_in_req", {r1_ack, r0_ack}, 2'b00);
      if (j == lat) begin
        mem_ack = 1; mem_rd_data = mdata;
      end else begin
        mem_rd_data = $urandom;
      end
      if (scramble) begin
        r0_addr = $urandom; r1_addr = $urandom; r0_wr_data = $urandom; r1_wr_data = $urandom;
        r0_rd_wr = $urandom_range(0, 1); r1_rd_wr = $urandom_range(0, 1);
      end
    end while (j != lat && j < TO);

    @(posedge clk);
    @(negedge clk);
    mem_ack = 0;
    drop_reqs();
    check("resp_ack", {r1_ack, r0_ack}, w ? 2'b10 : 2'b01);
    check("resp_err", {r1_err, r0_err}, err ? (w ? 2'b10 : 2'b01) : 2'b00);
    check("resp_data", w ? r1_rd_data : r0_rd_data, edata);
    check("other_data_held", w ? r0_rd_data : r1_rd_data, m_data[!w]);
    check("resp_no_mem_req", mem_req_valid, 1'b0);
    m_data[w] = edata;

    @(posedge clk);
    @(negedge clk);
    check("idle_no_ack", {r1_ack, r0_ack, mem_req_valid}, 3'b000);
    check("idle_data_hold", {r1_rd_data, r0_rd_data}, {m_data[1], m_data[0]});
    check("idle_owner_kept", owner, w);
    n_txn++;
    $display("txn %0d: v=%0d%0d owner=%0d %s addr=%h lat=%0d err=%0d data=%h",
             n_txn, v1, v0, w, wr ? "WR" : "RD", addr, lat, err, edata);
  endtask

  initial begin
    reset = 1; mem_ack = 0; mem_rd_data = 0;
    drop_reqs();
    do_reset();

    // Both requesters valid from reset: grants alternate starting at r0.
    for (int i = 0; i < 4; i++)
      do_txn(1, 1, 32'h100 + i, 32'h200 + i, 0, 0, 0, 0, 1 + i, 32'hA000 + i, 0);

    do_txn(1, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0);
    do_txn(0, 1, 32'h0, 32'h20, 32'h0, 32'h1234, 0, 1, 5, 32'hFFFF_FFFF, 0);

    // Watchdog: no ack at all, ack on the final allowed cycle, then normal.
    do_txn(1, 0, 32'h30, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h5555, 0);
    do_txn(0, 1, 32'h0, 32'h34, 32'h0, 32'h0, 0, 0, TO, 32'h7777, 0);
    do_txn(1, 0, 32'h38, 32'h0, 32'h0, 32'h0, 0, 0, 2, 32'h9999, 0);

    // Stray ack while idle with nothing pending.
    @(negedge clk);
    mem_ack = 1; mem_rd_data = 32'hBAD0BAD0;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 0;
    check("stray_idle_ack", {r1_ack, r0_ack, mem_req_valid}, 3'b000);
    check("stray_idle_data", {r1_rd_data, r0_rd_data}, {m_data[1], m_data[0]});
    do_txn(0, 1, 32'h0, 32'h44, 32'h0, 32'h0, 0, 0, 1, 32'h4444, 0);

    // Reset in the middle of REQ, then a late ack after release.
    r0_req_valid = 1; r0_addr = 32'h50; r0_rd_wr = 0;
    @(posedge clk);
    @(negedge clk);
    check("mid_req_valid", mem_req_valid, 1'b1);
    reset = 1;
    drop_reqs();
    #1;
    check("mid_reset_outs", all_outs(), '0);
    @(negedge clk);
    reset = 0;
    m_last = 1'b1; m_data[0] = '0; m_data[1] = '0;
    @(negedge clk);
    mem_ack = 1; mem_rd_data = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      mem_ack = 0;
      check("post_reset_stray", all_outs(), '0);
    end

    // Randomized traffic, including inputs changing during the transaction.
    for (int i = 0; i < 40; i++) begin
      int vv;
      vv = $urandom_range(1, 3);
      do_txn(vv[0], vv[1], $urandom, $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, TO + 2), $urandom, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
